// File: rtl/pe_col_drain_pkg.sv
// Shared types and default geometry for the PE column write-back drain.
// Tag field widths follow the default column geometry below.
package pe_col_drain_pkg;

    localparam int DRAIN_ROWS       = 4;
    localparam int DRAIN_WORDS      = 4;
    localparam int DRAIN_FIFO_DEPTH = 8;
    localparam int DRAIN_DW         = 32;

    localparam int DRAIN_RW = (DRAIN_ROWS  > 1) ? $clog2(DRAIN_ROWS)  : 1;
    localparam int DRAIN_WW = (DRAIN_WORDS > 1) ? $clog2(DRAIN_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        FIN
    } drain_state_t;

    typedef struct packed {
        logic [DRAIN_RW-1:0] row;
        logic [DRAIN_WW-1:0] word;
        logic                last;
    } wb_tag_t;

    localparam int WB_TAG_W = $bits(wb_tag_t);

endpackage

// File: rtl/wb_fifo.sv
// Synchronous first-word-fall-through FIFO: head visible the cycle after push, pop frees it same cycle.
// Pushes while full are dropped, so the writer must hold credits; count_o exposes occupancy for that.
module wb_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 37
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_dat_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         pop_dat_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             full;
    logic             wr;
    logic             rd;

    assign full      = (cnt_q == CNT_FULL);
    assign empty_o   = (cnt_q == '0);
    assign wr        = push_i && !full;
    assign rd        = pop_i && !empty_o;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = cnt_q;

    // Storage is not reset; consumers only look at it while non-empty.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (wr) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (rd) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_col_drain.sv
// Drains ROWS x WORDS accumulators from a PE column into a tagged valid/ready stream; done ROWS*WORDS+3 cycles after start at full rate.
// Strobes are only issued while FIFO occupancy plus the in-flight capture leaves room, so m_ready may stall forever.
module pe_col_drain
    import pe_col_drain_pkg::*;
#(
    parameter int ROWS       = DRAIN_ROWS,
    parameter int WORDS      = DRAIN_WORDS,
    parameter int FIFO_DEPTH = DRAIN_FIFO_DEPTH,
    parameter int DW         = DRAIN_DW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      wben,
    output logic [ROWS-1:0]           out_ready,
    input  logic [ROWS*DW-1:0]        out_sum_i,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DW-1:0]             m_data,
    output logic [$clog2(ROWS)-1:0]   m_row,
    output logic [$clog2(WORDS)-1:0]  m_word,
    output logic                      m_last
);

    localparam int RW = $clog2(ROWS);
    localparam int WW = $clog2(WORDS);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int FW = DW + WB_TAG_W;

    localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(WORDS - 1);
    localparam logic [CW-1:0] CREDITS   = CW'(FIFO_DEPTH);

    drain_state_t  state_q;
    logic [RW-1:0] row_cnt_q;
    logic [WW-1:0] word_cnt_q;
    logic          infl_vld_q;
    wb_tag_t       infl_tag_q;

    logic [CW-1:0] fifo_cnt;
    logic          fifo_empty;
    logic [FW-1:0] fifo_head;
    logic [FW-1:0] fifo_push_dat;
    wb_tag_t       head_tag;
    wb_tag_t       issue_tag;
    logic          credit_ok;
    logic          issue;
    logic          last_issue;
    logic          pop;
    logic          flush_clear;

    // The in-flight capture already owns a FIFO slot even though it has not been pushed yet.
    assign credit_ok  = (fifo_cnt + CW'(infl_vld_q)) < CREDITS;
    assign issue      = (state_q == DRAIN) && credit_ok;
    assign last_issue = issue && (row_cnt_q == ROW_LAST) && (word_cnt_q == WORD_LAST);
    assign issue_tag  = '{row: row_cnt_q, word: word_cnt_q, last: last_issue};
    assign out_ready  = issue ? (ROWS'(1) << row_cnt_q) : '0;

    assign pop         = m_valid && m_ready;
    assign flush_clear = !infl_vld_q && ((fifo_cnt == '0) || ((fifo_cnt == CW'(1)) && pop));

    assign busy = (state_q != IDLE);
    assign done = (state_q == FIN);
    assign wben = (state_q == DRAIN) || (state_q == FLUSH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            word_cnt_q <= '0;
            infl_vld_q <= 1'b0;
            infl_tag_q <= '0;
        end else begin
            infl_vld_q <= issue;
            if (issue) begin
                infl_tag_q <= issue_tag;
            end
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= DRAIN;
                        row_cnt_q  <= '0;
                        word_cnt_q <= '0;
                    end
                end
                DRAIN: begin
                    if (issue) begin
                        word_cnt_q <= word_cnt_q + WW'(1);
                        if (word_cnt_q == WORD_LAST) begin
                            row_cnt_q <= last_issue ? '0 : row_cnt_q + RW'(1);
                        end
                        if (last_issue) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_clear) begin
                        state_q <= FIN;
                    end
                end
                FIN:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // PE out_sum is registered, so the word strobed last cycle is on the bus now.
    assign fifo_push_dat = {infl_tag_q, out_sum_i[infl_tag_q.row*DW +: DW]};

    wb_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst),
        .push_i     (infl_vld_q),
        .push_dat_i (fifo_push_dat),
        .pop_i      (pop),
        .pop_dat_o  (fifo_head),
        .count_o    (fifo_cnt),
        .empty_o    (fifo_empty)
    );

    assign head_tag = fifo_head[FW-1 -: WB_TAG_W];
    assign m_valid  = !fifo_empty;
    assign m_data   = m_valid ? fifo_head[DW-1:0] : '0;
    assign m_row    = m_valid ? head_tag.row      : '0;
    assign m_word   = m_valid ? head_tag.word     : '0;
    assign m_last   = m_valid && head_tag.last;

endmodule

// File: doc/pe_col_drain.md
Name: pe_col_drain

Overview:
- Write-back drain stage directly downstream of one column of PEs.
- After a tile finishes, it raises wben to the column and sequences out_ready to each PE, one row at a time, for WORDS cycles per row.
- It captures each PE's registered out_sum and buffers it in a small FIFO. The buffered words stream out on a valid/ready port, tagged with row and word index, toward the result writer.

Parameters:
- ROWS, 4, PEs per column (rows drained)
- WORDS, 4, accumulator words per PE regfile (matches PE N); must be a power of 2
- FIFO_DEPTH, 8, result FIFO entries; power of 2, minimum 2
- DW, 32, data word width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse to begin draining; ignored unless the FSM is in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the last word has been accepted downstream
- wben  out  1  write-back enable, broadcast to every PE in the column
- out_ready  out  ROWS  one-hot per-PE read strobe
- out_sum_i  in  ROWS*DW  concatenated PE out_sum; row k occupies bits [k*DW +: DW]
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  DW  output word
- m_row  out  $clog2(ROWS)  source row of m_data
- m_word  out  $clog2(WORDS)  regfile index of m_data
- m_last  out  1  marks the final word of the drain (row ROWS-1, word WORDS-1)

Behaviour:
- Reset (rst low, asynchronous):
  - FSM goes to IDLE; FIFO is emptied; all counters clear to 0.
  - busy, done, wben, out_ready, m_valid and m_last are 0; m_data, m_row and m_word are 0.
  - Reset mid-drain abandons the drain. No done pulse is generated. PE pointers are not restored, so the system must also reset the PEs.
- FSM states: IDLE, DRAIN, FLUSH, FIN.
  - IDLE -> DRAIN on start.
  - DRAIN -> FLUSH the cycle after the final out_ready issue.
  - FLUSH -> FIN when the FIFO is empty and nothing is in flight.
  - FIN -> IDLE after one cycle; done=1 in FIN only.
- wben: 1 in DRAIN and FLUSH, 0 otherwise. It stays high through the final capture, because the PE only updates out_sum while wben is high.
- Issue rule (DRAIN only):
  - out_ready[row_cnt]=1 for one cycle only when fifo_count + inflight < FIFO_DEPTH.
  - At most one out_ready bit is high in any cycle.
  - Each issue advances word_cnt. When word_cnt wraps from WORDS-1 to 0, row_cnt increments.
  - Exactly WORDS issues per row, so each PE regfile pointer returns to 0.
- Capture latency: an issue at cycle t means out_sum_i[row] is valid at t+1.
  - A one-deep inflight register holds {row, word, last} for that capture.
  - At t+1 the FIFO pushes {data, tag}.
  - inflight clears unless a new issue occurs in the same cycle.
- Throughput: one word per cycle when m_ready is held high. Full column drain takes ROWS*WORDS + 3 cycles from start to done (16 words: done 19 cycles after start).
- Output:
  - m_valid = FIFO not empty; fields come from the FIFO head (first-word-fall-through).
  - Pop happens on m_valid && m_ready.
  - m_data and the tag fields are held stable while m_valid is high and m_ready is low.
- Simultaneous push and pop are allowed. When the FIFO is full, a push is impossible by construction of the credit rule; the bench asserts this.
- start received while busy is ignored, with no side effects.
- m_ready may stay low indefinitely. Issue then stalls once credits run out, with wben still high. The PEs hold out_sum because out_ready is low.

Decomposition:
- Add to params package:
  - drain_state_t enum {IDLE, DRAIN, FLUSH, FIN}
  - wb_tag_t struct {row, word, last}
  - DRAIN_DW = 32
- Sub-module: wb_fifo, a parameterised synchronous FIFO.
  - Parameters: DEPTH and WIDTH, with WIDTH = DW + tag.
  - Behaviour: first-word-fall-through, count output, async active-low reset.

Test Plan:
- Free flow: ROWS=4, WORDS=4; PE model returns 32'h{row,word}; start with m_ready=1 -> 16 words in order r0w0..r3w3, m_last only on r3w3, done exactly 19 cycles after start.
- Backpressure: m_ready=0 for 30 cycles after start -> exactly 8 out_ready issues, then no more and wben held high; after m_ready=1, the remaining 8 words arrive in order with no loss or duplication.
- Random m_ready at 50% -> the sequence matches the scoreboard, out_ready is always one-hot or zero, and each row receives exactly 4 strobes.
- start pulsed during DRAIN and during FLUSH -> ignored; a single done pulse and 16 words total.
- rst asserted low after 6 output words -> all outputs 0 asynchronously, FIFO empty, FSM back in IDLE, no done; a new start after rst is released drains 16 words again.
- Back-to-back drains: start asserted in the cycle after done -> second drain is identical, and PE pointer models are back at 0.
